// File: rtl/lccde_pkg.sv
// Shared types and helpers for the lccde_filter_mac difference-equation filter.
//   state_e    : FSM state encoding (IDLE, MAC)
//   B_BASE     : coefficient address of b0
//   a_base()   : coefficient address of a1 (equals NB)
//   addr_width : coefficient address width, at least 1
//   acc_width  : accumulator width DW+CW+clog2(NB+NA)+1
//   sat()      : clamp a wide signed value to a dw-bit two's complement range
package lccde_pkg;

  typedef enum logic [0:0] {IDLE, MAC} state_e;

  localparam int unsigned B_BASE = 0;

  function automatic int unsigned a_base(input int unsigned nb);
    return nb;
  endfunction

  function automatic int unsigned addr_width(input int unsigned ntaps);
    return (ntaps > 1) ? $clog2(ntaps) : 1;
  endfunction

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned cw,
                                            input int unsigned nb, input int unsigned na);
    return dw + cw + $clog2(nb + na) + 1;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                             input int unsigned dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/lccde_mac.sv
// Shared multiply-accumulate datapath for lccde_filter_mac.
// Optional build macro: LCCDE_ROUND_EN (round half up before the shift; default truncates).
// Ports:
//   clk, reset  : system clock, synchronous active-high reset (clears the accumulator)
//   clr_i       : load accumulator with zero (start of a new sample)
//   en_i        : accumulate this cycle's product
//   sub_i       : subtract the product instead of adding (feedback taps)
//   coef_i      : signed coefficient
//   operand_i   : signed sample operand
//   result_o    : sat((acc + / - coef*operand [+ half]) >>> FRAC), the value y takes
//                 on the last MAC cycle
module lccde_mac import lccde_pkg::*; #(
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 8,
  parameter int unsigned AW   = 20,
  parameter int unsigned FRAC = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 sub_i,
  input  logic signed [CW-1:0] coef_i,
  input  logic signed [DW-1:0] operand_i,
  output logic signed [DW-1:0] result_o
);

`ifdef LCCDE_ROUND_EN
  localparam logic signed [AW-1:0] RoundC =
      (FRAC > 0) ? (AW'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
`endif

  logic signed [CW+DW-1:0] prod;
  logic signed [AW-1:0]    prod_ext;
  logic signed [AW-1:0]    acc_q, acc_d, acc_next;
  logic signed [AW-1:0]    biased, shifted;
  logic signed [63:0]      wide;

  always_comb begin
    prod     = $signed({{DW{coef_i[CW-1]}}, coef_i}) *
               $signed({{CW{operand_i[DW-1]}}, operand_i});
    prod_ext = {{(AW-CW-DW){prod[CW+DW-1]}}, prod};
    // Subtracting a*y is the same as adding a*(-y) without needing a DW+1 bit operand.
    acc_next = sub_i ? (acc_q - prod_ext) : (acc_q + prod_ext);
`ifdef LCCDE_ROUND_EN
    biased   = acc_next + RoundC;
`else
    biased   = acc_next;
`endif
    shifted  = biased >>> FRAC;
    wide     = {{(64-AW){shifted[AW-1]}}, shifted};
    result_o = DW'(sat(wide, DW));
  end

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/lccde_filter_mac.sv
// Constant-coefficient linear difference-equation filter with one shared multiplier:
//   y[n] = sat((sum b_k*x[n-k] - sum a_j*y[n-j]) >>> FRAC)
// Optional build macro: LCCDE_ROUND_EN (round half up; default truncates).
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   coef_we/addr/data   : coefficient write, 0..NB-1 -> b_k, NB..NB+NA-1 -> a_1..a_NA,
//                         taken only in IDLE; out-of-range addresses are dropped
//   in_valid/in_ready/x : sample input handshake
//   out_valid/y         : one-cycle pulse with new y; y holds between pulses
//   busy                : high while taps are being accumulated
module lccde_filter_mac import lccde_pkg::*; #(
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 8,
  parameter int unsigned FRAC = 6,
  parameter int unsigned NB   = 3,
  parameter int unsigned NA   = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                coef_we,
  input  logic [addr_width(NB+NA)-1:0]        coef_addr,
  input  logic signed [CW-1:0]                coef_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [DW-1:0]                x,
  output logic                                out_valid,
  output logic signed [DW-1:0]                y,
  output logic                                busy
);

  localparam int unsigned NT    = NB + NA;
  localparam int unsigned AddrW = addr_width(NT);
  localparam int unsigned AW    = acc_width(DW, CW, NB, NA);
  localparam int unsigned ABase = a_base(NB);
  localparam int unsigned NaR   = (NA > 0) ? NA : 1;

  localparam logic [AddrW-1:0]     LastIdx = AddrW'(NT - 1);
  localparam logic signed [CW-1:0] DefB0   = CW'(1 << FRAC);

  state_e state_q, state_d;
  logic [AddrW-1:0] idx_q, idx_d;

  logic signed [DW-1:0] xh_q   [NB];
  logic signed [DW-1:0] yh_q   [NaR];
  logic signed [CW-1:0] coef_q [NT];
  logic signed [DW-1:0] y_q;
  logic                 out_valid_q;

  logic                 accept;
  logic                 last;
  logic                 coef_wr;
  logic signed [CW-1:0] mac_coef;
  logic signed [DW-1:0] mac_operand;
  logic                 mac_sub;
  logic signed [DW-1:0] mac_result;

  // FSM next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        last = (idx_q == LastIdx);
        if (last) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == MAC);
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign coef_wr   = coef_we && (state_q == IDLE) && (32'(coef_addr) < NT);

  // Tap select: b taps read x history, a taps read y history and subtract.
  always_comb begin
    mac_coef    = '0;
    mac_operand = '0;
    mac_sub     = 1'b0;
    for (int unsigned k = 0; k < NT; k++) begin
      if (32'(idx_q) == k) mac_coef = coef_q[k];
    end
    for (int unsigned k = 0; k < NB; k++) begin
      if (32'(idx_q) == B_BASE + k) mac_operand = xh_q[k];
    end
    for (int unsigned k = 0; k < NA; k++) begin
      if (32'(idx_q) == ABase + k) begin
        mac_operand = yh_q[k];
        mac_sub     = 1'b1;
      end
    end
  end

  lccde_mac #(
    .DW   (DW),
    .CW   (CW),
    .AW   (AW),
    .FRAC (FRAC)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (accept),
    .en_i      (busy),
    .sub_i     (mac_sub),
    .coef_i    (mac_coef),
    .operand_i (mac_operand),
    .result_o  (mac_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned k = 0; k < NB; k++) xh_q[k] <= '0;
      for (int unsigned k = 0; k < NaR; k++) yh_q[k] <= '0;
      // Pass-through: b0 = 1.0, everything else zero.
      for (int unsigned k = 0; k < NT; k++) coef_q[k] <= (k == B_BASE) ? DefB0 : '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= last;
      for (int unsigned k = 0; k < NT; k++) begin
        if (coef_wr && (32'(coef_addr) == k)) coef_q[k] <= coef_data;
      end
      if (accept) begin
        xh_q[0] <= x;
        for (int unsigned k = 1; k < NB; k++) xh_q[k] <= xh_q[k-1];
      end
      if (last) begin
        y_q <= mac_result;
        if (NA > 0) begin
          yh_q[0] <= mac_result;
          for (int unsigned k = 1; k < NaR; k++) yh_q[k] <= yh_q[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_lccde_filter_mac.sv
// Directed self-checking bench for lccde_filter_mac with default parameters
// (DW=8, CW=8, FRAC=6, NB=3, NA=2). Expected values follow LCCDE_ROUND_EN when defined.
module tb_lccde_filter_mac;

  logic              clk = 1'b0;
  logic              reset;
  logic              coef_we;
  logic [2:0]        coef_addr;
  logic signed [7:0] coef_data;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] x;
  logic              out_valid;
  logic signed [7:0] y;
  logic              busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lccde_filter_mac dut (
    .clk       (clk),
    .reset     (reset),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .y         (y),
    .busy      (busy)
  );

  task automatic do_reset();
    reset     = 1'b1;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    in_valid  = 1'b0;
    x         = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic write_coef(input logic [2:0] a, input logic signed [7:0] d);
    coef_addr = a;
    coef_data = d;
    coef_we   = 1'b1;
    @(posedge clk);
    #1 coef_we = 1'b0;
  endtask

  // Waits up to 20 cycles for out_valid; lat = cycles waited, -1 on timeout.
  task automatic wait_out(output logic signed [7:0] yv, output int lat);
    lat = -1;
    yv  = 'x;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        lat = c;
        yv  = y;
        break;
      end
    end
  endtask

  // Holds x until accepted, then waits for the result pulse.
  task automatic send(input logic signed [7:0] xv, output logic signed [7:0] yv,
                      output int lat, output int acc_cyc);
    int n;
    x        = xv;
    in_valid = 1'b1;
    n        = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
    wait_out(yv, lat);
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (y !== 8'sd0) $display("FAIL reset_y: got %0d expected 0", y); else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_default();
    logic signed [7:0] xv, yv;
    int lat, ac, prev;
    prev = 0;
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      xv = (i == 10) ? 8'sd0 : 8'(i);
      send(xv, yv, lat, ac);
      total_cnt++;
      if (yv !== xv) $display("FAIL default_y[%0d]: got %0d expected %0d", i, yv, xv);
      else pass_cnt++;
      total_cnt++;
      if (lat != 5) $display("FAIL default_latency[%0d]: got %0d expected 5", i, lat);
      else pass_cnt++;
      if (i > 1) begin
        total_cnt++;
        if (ac - prev != 6) $display("FAIL default_spacing[%0d]: got %0d expected 6", i, ac - prev);
        else pass_cnt++;
      end
      prev = ac;
    end
  endtask

  task automatic test_sum();
    logic signed [7:0] xs [4] = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    logic signed [7:0] ex [4] = '{8'sd1, 8'sd3, 8'sd6, 8'sd9};
    logic signed [7:0] yv;
    int lat, ac;
    do_reset();
    write_coef(3'd1, 8'sd64);
    write_coef(3'd2, 8'sd64);
    for (int i = 0; i < 4; i++) begin
      send(xs[i], yv, lat, ac);
      total_cnt++;
      if (yv !== ex[i]) $display("FAIL sum_y[%0d]: got %0d expected %0d", i, yv, ex[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_feedback();
    logic signed [7:0] xs [4] = '{8'sd64, 8'sd0, 8'sd0, 8'sd0};
    logic signed [7:0] ex [4] = '{8'sd64, 8'sd32, 8'sd16, 8'sd8};
    logic signed [7:0] yv;
    int lat, ac;
    do_reset();
    write_coef(3'd3, -8'sd32);
    for (int i = 0; i < 4; i++) begin
      send(xs[i], yv, lat, ac);
      total_cnt++;
      if (yv !== ex[i]) $display("FAIL feedback_y[%0d]: got %0d expected %0d", i, yv, ex[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    logic signed [7:0] exp_pos [3] = '{8'sd100, 8'sd127, 8'sd127};
    logic signed [7:0] exp_neg [2] = '{-8'sd100, -8'sd128};
    logic signed [7:0] yv;
    int lat, ac;
    do_reset();
    write_coef(3'd3, -8'sd64);
    for (int i = 0; i < 3; i++) begin
      send(8'sd100, yv, lat, ac);
      total_cnt++;
      if (yv !== exp_pos[i]) $display("FAIL sat_pos_y[%0d]: got %0d expected %0d", i, yv, exp_pos[i]);
      else pass_cnt++;
    end
    do_reset();
    write_coef(3'd3, -8'sd64);
    for (int i = 0; i < 2; i++) begin
      send(-8'sd100, yv, lat, ac);
      total_cnt++;
      if (yv !== exp_neg[i]) $display("FAIL sat_neg_y[%0d]: got %0d expected %0d", i, yv, exp_neg[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic signed [7:0] yv;
    int lat, ac, n, seen;
    do_reset();
    write_coef(3'd0, 8'sd127);
    x        = 8'sd9;
    in_valid = 1'b1;
    n        = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL mid_reset_in_ready: got %b expected 1", in_ready);
    else pass_cnt++;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk);
      #1;
    end
    total_cnt++;
    if (seen != 0) $display("FAIL mid_reset_no_pulse: got %0d pulses expected 0", seen);
    else pass_cnt++;
    // b0 must be back at 1.0 after the reset.
    send(8'sd5, yv, lat, ac);
    total_cnt++;
    if (yv !== 8'sd5) $display("FAIL mid_reset_y: got %0d expected 5", yv); else pass_cnt++;
  endtask

  task automatic test_busy_write();
    logic signed [7:0] yv;
    int lat, ac, n;
    do_reset();
    x        = 8'sd7;
    in_valid = 1'b1;
    n        = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL busy_flag: got %b expected 1", busy); else pass_cnt++;
    coef_addr = 3'd0;
    coef_data = 8'sd0;
    coef_we   = 1'b1;
    @(posedge clk);
    #1 coef_we = 1'b0;
    wait_out(yv, lat);
    total_cnt++;
    if (yv !== 8'sd7) $display("FAIL busy_write_y: got %0d expected 7", yv); else pass_cnt++;
    send(8'sd9, yv, lat, ac);
    total_cnt++;
    if (yv !== 8'sd9) $display("FAIL busy_write_next_y: got %0d expected 9", yv); else pass_cnt++;
  endtask

  task automatic test_write_and_accept();
    logic signed [7:0] yv;
    int lat;
    do_reset();
    // Out-of-range addresses must not disturb any tap.
    write_coef(3'd5, 8'sd0);
    write_coef(3'd7, 8'sd0);
    coef_addr = 3'd0;
    coef_data = 8'sd32;
    coef_we   = 1'b1;
    x         = 8'sd10;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    coef_we  = 1'b0;
    in_valid = 1'b0;
    wait_out(yv, lat);
    total_cnt++;
    if (yv !== 8'sd5) $display("FAIL write_and_accept_y: got %0d expected 5", yv); else pass_cnt++;
  endtask

  task automatic test_round();
    logic signed [7:0] yv, e_pos, e_neg;
    int lat, ac;
`ifdef LCCDE_ROUND_EN
    e_pos = 8'sd2;
    e_neg = -8'sd1;
`else
    e_pos = 8'sd1;
    e_neg = -8'sd2;
`endif
    do_reset();
    write_coef(3'd0, 8'sd32);
    send(8'sd3, yv, lat, ac);
    total_cnt++;
    if (yv !== e_pos) $display("FAIL round_pos_y: got %0d expected %0d", yv, e_pos); else pass_cnt++;
    send(-8'sd3, yv, lat, ac);
    total_cnt++;
    if (yv !== e_neg) $display("FAIL round_neg_y: got %0d expected %0d", yv, e_neg); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_default();
    test_sum();
    test_feedback();
    test_saturation();
    test_reset_mid();
    test_busy_write();
    test_write_and_accept();
    test_round();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
